// File: rtl/minterm_sweeper.sv
// minterm_sweeper: drives {A,B,C,D} through codes 0..15, samples Y, builds a truth mask.
// Optional early-abort on first wrong sample: define MINTERM_SWEEPER_EARLY_FAIL_EN.
module minterm_sweeper #(
    parameter int unsigned SETTLE = 0,
    parameter logic [15:0] EXPECT = 16'h001E
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        Y,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic        match
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
    ,
    output logic [3:0]  fail_idx
`endif
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_FIN
    } state_t;

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_code;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_truth;
    logic        r_match;
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
    logic [3:0]  r_fail_idx;
`endif

    logic [15:0] w_truth_nx;
    logic [3:0]  w_idx_nx;
    logic        w_bad;

    // Mask with the current sample merged in at the current index
    always_comb begin
        w_truth_nx        = r_truth;
        w_truth_nx[r_idx] = Y;
    end

    assign w_idx_nx = r_idx + 4'd1;

`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
    assign w_bad = (Y != EXPECT[r_idx]);
`else
    assign w_bad = 1'b0;
`endif

    // Sweep sequencer: code stepping, settle wait, sampling and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            r_code     <= 4'd0;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_truth    <= 16'd0;
            r_match    <= 1'b0;
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
            r_fail_idx <= 4'd0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_code <= 4'd0;
                    if (start) begin
                        r_idx   <= 4'd0;
                        r_truth <= 16'd0;
                        r_match <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
                        r_fail_idx <= 4'd0;
`endif
                        if (LP_SETTLE != 4'd0) begin
                            r_cnt   <= LP_SETTLE;
                            r_state <= S_SETTLE;
                        end else begin
                            r_state <= S_SAMPLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_truth <= w_truth_nx;
                    if (r_idx == 4'd15 || w_bad) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_match <= (w_truth_nx == EXPECT) && !w_bad;
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
                        if (w_bad) begin
                            r_fail_idx <= r_idx;
                        end
`endif
                    end else begin
                        r_idx  <= w_idx_nx;
                        r_code <= w_idx_nx;
                        if (LP_SETTLE != 4'd0) begin
                            r_cnt   <= LP_SETTLE;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_FIN: begin
                    r_code  <= 4'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign A     = r_code[3];
    assign B     = r_code[2];
    assign C     = r_code[1];
    assign D     = r_code[0];
    assign busy  = r_busy;
    assign done  = r_done;
    assign truth = r_truth;
    assign match = r_match;
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
    assign fail_idx = r_fail_idx;
`endif

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb_minterm_sweeper: directed plus randomized sweeps on two instances (SETTLE=0 and SETTLE=2)
// against a truth-table level reference model.
module tb_minterm_sweeper;

    localparam logic [15:0] EXP = 16'h001E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st0, st2;
    logic        a0, b0, c0, d0, a2, b2, c2, d2;
    logic        y0, y2;
    logic        busy0, busy2, done0, done2, match0, match2;
    logic [15:0] tr0, tr2;
    logic [15:0] tab0, tab2;
    logic [3:0]  fi0, fi2;

    int n_checks = 0;
    int n_fail   = 0;

    logic        sel;
    logic [3:0]  c_code;
    logic        c_busy, c_done, c_match;
    logic [15:0] c_truth;
    logic [3:0]  c_fi;

    assign y0 = tab0[{a0, b0, c0, d0}];
    assign y2 = tab2[{a2, b2, c2, d2}];

    minterm_sweeper #(.SETTLE(0), .EXPECT(EXP)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st0),
        .A(a0), .B(b0), .C(c0), .D(d0), .Y(y0),
        .busy(busy0), .done(done0), .truth(tr0), .match(match0)
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
        , .fail_idx(fi0)
`endif
    );

    minterm_sweeper #(.SETTLE(2), .EXPECT(EXP)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2),
        .A(a2), .B(b2), .C(c2), .D(d2), .Y(y2),
        .busy(busy2), .done(done2), .truth(tr2), .match(match2)
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
        , .fail_idx(fi2)
`endif
    );

`ifndef MINTERM_SWEEPER_EARLY_FAIL_EN
    assign fi0 = 4'd0;
    assign fi2 = 4'd0;
`endif

    assign c_code  = sel ? {a2, b2, c2, d2} : {a0, b0, c0, d0};
    assign c_busy  = sel ? busy2 : busy0;
    assign c_done  = sel ? done2 : done0;
    assign c_truth = sel ? tr2 : tr0;
    assign c_match = sel ? match2 : match0;
    assign c_fi    = sel ? fi2 : fi0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) st2 = v;
        else st0 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: how many codes get sampled, resulting mask, match, fail index
    function automatic void predict(input logic [15:0] t, output int nsamp,
                                    output logic [15:0] et, output logic em,
                                    output logic [3:0] efi);
        nsamp = 16;
        et    = t;
        efi   = 4'd0;
        em    = (t == EXP);
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
        for (int i = 0; i < 16; i++) begin
            if (t[i] != EXP[i]) begin
                nsamp = i + 1;
                efi   = 4'(i);
                break;
            end
        end
        if (nsamp < 16) et = t & 16'((32'd1 << nsamp) - 32'd1);
`endif
    endfunction

    task automatic sweep(input logic s, input logic [15:0] t, input string tag, input int poke);
        int          per;
        int          len;
        int          nsamp;
        logic [15:0] et;
        logic        em;
        logic [3:0]  efi;
        sel = s;
        per = s ? 3 : 1;
        if (s) tab2 = t;
        else tab0 = t;
        predict(t, nsamp, et, em, efi);
        len = nsamp * per;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int k = 0; k < len; k++) begin
            chk({tag, "_busy"}, 32'(c_busy), 32'd1);
            chk({tag, "_done_early"}, 32'(c_done), 32'd0);
            chk({tag, "_code"}, 32'(c_code), 32'(k / per));
            set_start(k == poke - 1);
            tick();
        end
        set_start(1'b0);
        chk({tag, "_done"}, 32'(c_done), 32'd1);
        chk({tag, "_busy_fin"}, 32'(c_busy), 32'd0);
        chk({tag, "_truth"}, 32'(c_truth), 32'(et));
        chk({tag, "_match"}, 32'(c_match), 32'(em));
`ifdef MINTERM_SWEEPER_EARLY_FAIL_EN
        chk({tag, "_fail_idx"}, 32'(c_fi), 32'(efi));
`endif
        tick();
        chk({tag, "_done_drop"}, 32'(c_done), 32'd0);
        chk({tag, "_code_idle"}, 32'(c_code), 32'd0);
        chk({tag, "_truth_hold"}, 32'(c_truth), 32'(et));
        chk({tag, "_match_hold"}, 32'(c_match), 32'(em));
        tick();
        chk({tag, "_no_restart"}, 32'(c_busy), 32'd0);
    endtask

    initial begin
        int          kb;
        logic [15:0] rt;
        rst_n = 1'b0;
        st0   = 1'b0;
        st2   = 1'b0;
        sel   = 1'b0;
        tab0  = EXP;
        tab2  = EXP;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            chk("rst_busy", 32'(c_busy), 32'd0);
            chk("rst_done", 32'(c_done), 32'd0);
            chk("rst_code", 32'(c_code), 32'd0);
            chk("rst_truth", 32'(c_truth), 32'd0);
            chk("rst_match", 32'(c_match), 32'd0);
            chk("rst_fi", 32'(c_fi), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        sweep(1'b0, EXP, "ok0", 0);
        sweep(1'b0, 16'hFF00, "yA", 0);
        sweep(1'b1, EXP, "ok2", 20);

        // reset in the middle of a sweep at index 7
        sel  = 1'b0;
        tab0 = EXP;
        st0  = 1'b1;
        tick();
        st0 = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("mid_code7", 32'(c_code), 32'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_busy", 32'(c_busy), 32'd0);
        chk("mid_done", 32'(c_done), 32'd0);
        chk("mid_code", 32'(c_code), 32'd0);
        chk("mid_truth", 32'(c_truth), 32'd0);
        chk("mid_match", 32'(c_match), 32'd0);
        tick();
        sweep(1'b0, EXP, "post_rst", 0);

        // start held high: sweeps accepted at edges 0, 18, 36
        sel  = 1'b0;
        tab0 = EXP;
        st0  = 1'b1;
        tick();
        for (int k = 0; k <= 60; k++) begin
            kb = 0;
            for (int i = 0; i < 3; i++) begin
                if (k >= 18 * i && k <= 18 * i + 15) kb = 1;
            end
            chk("b2b_done", 32'(done0), 32'(k == 16 || k == 34 || k == 52));
            chk("b2b_busy", 32'(busy0), 32'(kb));
            if (k == 39) st0 = 1'b0;
            tick();
        end
        chk("b2b_truth", 32'(tr0), 32'(EXP));
        chk("b2b_match", 32'(match0), 32'd1);

        sweep(1'b0, 16'hFFFF, "y1", 0);
        sweep(1'b1, 16'hFFFF, "y1s", 0);

        for (int r = 0; r < 8; r++) begin
            if (r % 3 == 0) rt = 16'($urandom);
            else rt = EXP ^ 16'(32'd1 << $urandom_range(15));
            sweep(r[0], rt, "rand", (r[0] && r == 3) ? 10 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
